// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and helpers for the mux_arb arbiter.
//   DEFAULT_WIDTH    - default data bits per channel
//   DEFAULT_CHANNELS - default number of input channels
//   sel_w()          - width of a channel index, never less than 1
package mux_arb_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_CHANNELS = 4;

    function automatic int sel_w(input int channels);
        return ($clog2(channels) < 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/mux_arb_if.sv
// mux_arb_if: handshake bundle between the input channels, the arbiter and
// the downstream consumer.
//   in_data   - packed channel data, channel i at [i*Width +: Width]
//   in_valid  - per-channel valid
//   in_ready  - per-channel ready, one-hot or zero
//   out_data  - selected word
//   out_valid - out_data holds an accepted word
//   out_ready - downstream accepts out_data
//   out_sel   - index of the channel that supplied out_data
// Modports: slave = arbiter side, master = producer/consumer side.
interface mux_arb_if
    import mux_arb_pkg::*;
#(
    parameter int Width    = DEFAULT_WIDTH,
    parameter int Channels = DEFAULT_CHANNELS
);
    localparam int SelW = sel_w(Channels);

    logic [Channels*Width-1:0] in_data;
    logic [Channels-1:0]       in_valid;
    logic [Channels-1:0]       in_ready;
    logic [Width-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SelW-1:0]           out_sel;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

endinterface

// File: rtl/mux_arb_penc.sv
// mux_arb_penc: circular priority encoder. Starting at ptr and wrapping past
// Channels-1 back to 0, the first set bit of req is granted.
//   req     - request vector
//   ptr     - index searched first (must be < Channels)
//   gnt     - one-hot grant, zero when req is zero
//   gnt_idx - index of the granted bit, zero when nothing is granted
module mux_arb_penc
    import mux_arb_pkg::*;
#(
    parameter  int Channels = DEFAULT_CHANNELS,
    localparam int SelW     = sel_w(Channels)
) (
    input  logic [Channels-1:0] req,
    input  logic [SelW-1:0]     ptr,
    output logic [Channels-1:0] gnt,
    output logic [SelW-1:0]     gnt_idx
);

    logic            found;
    logic [SelW:0]   pos;

    // One extra bit on pos: ptr + k reaches at most 2*Channels-2 before the wrap.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < Channels; k++) begin
            pos = {1'b0, ptr} + (SelW+1)'(k);
            if (pos >= (SelW+1)'(Channels)) begin
                pos = pos - (SelW+1)'(Channels);
            end
            if (!found && req[pos[SelW-1:0]]) begin
                found                = 1'b1;
                gnt[pos[SelW-1:0]]   = 1'b1;
                gnt_idx              = pos[SelW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// mux_arb: N-to-1 valid/ready arbiter with a single registered output slot.
// A channel is accepted when the slot is empty or being drained this cycle;
// the accepted word appears on out_data one cycle later together with its
// channel index on out_sel.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mux_arb_if.slave handshake bundle
// Build option: define MUX_ARB_RR_EN for round-robin arbitration (pointer
// moves to one past the last winner); without it the lowest valid index wins
// and no pointer register exists.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int Width    = DEFAULT_WIDTH,
    parameter int Channels = DEFAULT_CHANNELS
) (
    input logic       clk,
    input logic       rst,
    mux_arb_if.slave  bus
);

    localparam int SelW = sel_w(Channels);

    logic [SelW-1:0]     ptr;
    logic [Channels-1:0] gnt;
    logic [SelW-1:0]     gnt_idx;
    logic [Width-1:0]    gnt_data;
    logic [Width-1:0]    data_q;
    logic [SelW-1:0]     sel_q;
    logic                valid_q;
    logic                slot_free;
    logic                xfer;

`ifdef MUX_ARB_RR_EN
    logic [SelW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= (gnt_idx == SelW'(Channels - 1)) ? '0 : gnt_idx + SelW'(1);
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    mux_arb_penc #(
        .Channels (Channels)
    ) u_penc (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign slot_free    = !valid_q || bus.out_ready;
    // Reset gates the grant so nothing is accepted on a reset edge.
    assign xfer         = !rst && slot_free && (|gnt);
    assign bus.in_ready = xfer ? gnt : '0;

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < Channels; i++) begin
            if (gnt[i]) begin
                gnt_data = bus.in_data[i*Width +: Width];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= gnt_data;
            sel_q   <= gnt_idx;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter: Width, default 32, data bits per channel.
REQ-002 Parameter: Channels, default 4, number of input channels; legal range 2..16.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: in_data  input  Channels*Width  packed channel data; channel i occupies bits [i*Width +: Width].
REQ-006 Port: in_valid  input  Channels  per-channel valid.
REQ-007 Port: in_ready  output  Channels  per-channel ready; one-hot or zero.
REQ-008 Port: out_data  output  Width  registered selected data.
REQ-009 Port: out_valid  output  1  out_data holds an accepted word.
REQ-010 Port: out_ready  input  1  downstream accepts out_data.
REQ-011 Port: out_sel  output  SelW  index of the channel that supplied out_data; SelW = $clog2(Channels).

Function
REQ-012 Slot free: SHALL be defined as (!out_valid || out_ready).
REQ-013 Grant: SHALL be computed combinationally from in_valid and the priority pointer; in_ready[g] SHALL be high only when the slot is free.
REQ-014 Transfer: a channel transfer SHALL occur when in_valid[i] && in_ready[i]; on that edge out_data <= channel i data, out_sel <= i, and out_valid <= 1.
REQ-015 Drain: when out_valid && out_ready and no channel transfers, out_valid SHALL go to 0; out_data and out_sel SHALL hold their values.
REQ-016 Latency: 1 cycle from input transfer to out_valid; sustained throughput SHALL be 1 word/cycle when out_ready is held high.
REQ-017 Backpressure: while out_valid && !out_ready, all in_ready SHALL be 0 and out_data, out_sel, out_valid SHALL hold.
REQ-018 Idle: with no in_valid bits set, in_ready SHALL be all zero and the pointer SHALL hold.
REQ-019 Pointer: after a transfer from channel g, the pointer SHALL become (g+1) mod Channels (wrap-around from Channels-1 to 0).
REQ-020 Search: starting at the pointer, the lowest index with in_valid set, searching circularly, SHALL be granted.
REQ-021 Input stability: in_valid dropping without a transfer SHALL NOT change any state.

Reset
REQ-022 While rst is high at a clock edge, the block SHALL set out_valid=0, out_data=0, out_sel=0, and pointer=0.
REQ-023 While rst is high, in_ready SHALL be forced to all zero.
REQ-024 Reset asserted mid-transfer SHALL discard the held word; no transfer SHALL be counted on that edge.

Configuration
REQ-025 Macro MUX_ARB_RR_EN defined: round-robin arbitration per REQ-019/REQ-020.
REQ-026 Macro MUX_ARB_RR_EN undefined: fixed priority; the lowest-index valid channel SHALL always win, and no pointer register SHALL exist. All other behaviour is unchanged.

Structure
REQ-027 Package mux_arb_pkg SHALL hold the default Width and Channels constants and the SelW computation function, with a minimum of 1.
REQ-028 The circular priority search SHALL be a sub-module, mux_arb_penc, with inputs req[Channels] and ptr[SelW] and outputs gnt[Channels] and gnt_idx[SelW].
REQ-029 Total RTL SHALL be 120-400 lines and contain no latches; all outputs except in_ready SHALL be registered.

Verification
REQ-030 Reset: drive rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
REQ-031 Round-robin: Channels=4, all valid, out_ready=1, data = channel index -> out_sel sequence 0,1,2,3,0 on consecutive cycles, with first out_valid one cycle after release.
REQ-032 Backpressure: out_ready=0 with out_valid=1, data 32'hA5A5_0001 -> out_data holds for 5 cycles and in_ready=0; release -> next word appears next cycle.
REQ-033 Sparse wrap: pointer=3 and only in_valid[1] set -> channel 1 granted, then pointer=2; next in_valid=4'b0101 -> channel 2 granted.
REQ-034 Fixed mode: MUX_ARB_RR_EN undefined, in_valid=4'b0110 held for 3 cycles -> out_sel=1 every cycle.
REQ-035 Mid-operation reset: rst=1 pulsed while out_valid=1 and out_ready=0 -> out_valid=0 next cycle; first post-reset grant goes to the lowest-index valid channel.
